boa_muldiv_sched: RTL and testbench

Issue/ordering controller for the RV32M unit. It accepts M-extension operations from the execute stage over a valid/ready handshake and drives an external zero-latency multiplier (boa_mul_simple) and an external pipelined divider (boa_div_pipelined, latency DIV_LAT). It tracks in-flight divides, keeps results strictly in request order, and buffers results in an output FIFO with backpressure. It sits between the decode/execute pipeline and writeback.

---
 rtl/boa_muldiv_sched.sv | 153 +++++++++++++++
 tb/tb_boa_muldiv_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boa_muldiv_sched.sv
// boa_muldiv_sched: in-order issue/retire controller for the RV32M unit.
// Drives an external zero-latency multiplier and a pipelined divider; results leave through a credit-checked FIFO.
module boa_muldiv_sched #(
  parameter int DIV_LAT   = 4,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_lhs,
  input  logic [31:0]      req_rhs,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_u_lhs,
  output logic             mul_u_rhs,
  output logic [31:0]      mul_lhs,
  output logic [31:0]      mul_rhs,
  input  logic [63:0]      mul_res,
  output logic             div_u,
  output logic [31:0]      div_lhs,
  output logic [31:0]      div_rhs,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_r
);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int IF_W  = $clog2(DIV_LAT + 1);
  localparam int SUM_W = $clog2(OUT_DEPTH + DIV_LAT + 1);
  localparam int LAST  = DIV_LAT - 1;

  logic [DIV_LAT-1:0] trk_valid_q, trk_valid_d;
  logic [DIV_LAT-1:0] trk_rem_q, trk_rem_d;
  logic [TAG_W-1:0]   trk_tag_q [DIV_LAT];
  logic [TAG_W-1:0]   trk_tag_d [DIV_LAT];

  logic [31:0]        fifo_data_q [OUT_DEPTH];
  logic [TAG_W-1:0]   fifo_tag_q  [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;

  logic [IF_W-1:0]    inflight;
  logic               is_mul, accept, push, pop;
  logic [31:0]        push_data;
  logic [TAG_W-1:0]   push_tag;

  assign mul_lhs   = req_lhs;
  assign mul_rhs   = req_rhs;
  assign div_lhs   = req_lhs;
  assign div_rhs   = req_rhs;
  assign mul_u_lhs = (req_op == 3'd3);
  assign mul_u_rhs = (req_op == 3'd2) || (req_op == 3'd3);
  assign div_u     = (req_op == 3'd5) || (req_op == 3'd7);

  // Output is forced to zero while empty so the reset view is clean without resetting storage.
  assign resp_valid = (fifo_count_q != '0);
  assign resp_data  = resp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_tag   = resp_valid ? fifo_tag_q[rd_ptr_q] : '0;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DIV_LAT; i++) begin
      inflight = inflight + IF_W'(trk_valid_q[i]);
    end
    is_mul = !req_op[2];
    // Every accepted, unreturned op holds one credit; a same-edge pop is deliberately not counted.
    req_ready = !flush
             && ((SUM_W'(fifo_count_q) + SUM_W'(inflight)) < SUM_W'(OUT_DEPTH))
             && !(is_mul && (inflight != '0));
    accept = req_valid && req_ready;
  end

  always_comb begin
    trk_valid_d    = '0;
    trk_rem_d      = '0;
    trk_valid_d[0] = accept && !is_mul;
    trk_rem_d[0]   = req_op[1];
    trk_tag_d[0]   = req_tag;
    for (int i = 1; i < DIV_LAT; i++) begin
      trk_valid_d[i] = trk_valid_q[i-1];
      trk_rem_d[i]   = trk_rem_q[i-1];
      trk_tag_d[i]   = trk_tag_q[i-1];
    end
    if (flush) begin
      trk_valid_d = '0;
    end
  end

  always_comb begin
    // A retiring divide and an accepted multiply can never coincide: multiplies wait for an empty tracker.
    push      = !flush && (trk_valid_q[LAST] || (accept && is_mul));
    push_data = (req_op == 3'd0) ? mul_res[31:0] : mul_res[63:32];
    push_tag  = req_tag;
    if (trk_valid_q[LAST]) begin
      push_data = trk_rem_q[LAST] ? div_r : div_q;
      push_tag  = trk_tag_q[LAST];
    end
    pop          = resp_valid && resp_ready;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_valid_q  <= '0;
      trk_rem_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      trk_valid_q  <= trk_valid_d;
      trk_rem_q    <= trk_rem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in trk_valid_q and fifo_count_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIV_LAT; i++) begin
      trk_tag_q[i] <= trk_tag_d[i];
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_tag_q[wr_ptr_q]  <= push_tag;
    end
  end
endmodule

// File: tb/tb_boa_muldiv_sched.sv
// Bench for boa_muldiv_sched: directed test-plan steps then random traffic, scored against an
// ordered expected-result queue built from RV32M arithmetic and the request/latency rules.
`timescale 1ns/1ps
module tb_boa_muldiv_sched;
  localparam int DIV_LAT   = 4;
  localparam int OUT_DEPTH = 4;
  localparam int TAG_W     = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = '0;
  logic [31:0]      req_lhs = '0;
  logic [31:0]      req_rhs = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             mul_u_lhs, mul_u_rhs, div_u;
  logic [31:0]      mul_lhs, mul_rhs, div_lhs, div_rhs, div_q, div_r;
  logic [63:0]      mul_res;

  always #5 clk = ~clk;

  boa_muldiv_sched #(.DIV_LAT(DIV_LAT), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
    .mul_u_lhs(mul_u_lhs), .mul_u_rhs(mul_u_rhs), .mul_lhs(mul_lhs), .mul_rhs(mul_rhs),
    .mul_res(mul_res),
    .div_u(div_u), .div_lhs(div_lhs), .div_rhs(div_rhs), .div_q(div_q), .div_r(div_r)
  );

  // Attached multiplier: combinational 64-bit product with per-operand signedness.
  logic [63:0] mul_a64, mul_b64;
  always_comb begin
    mul_a64 = mul_u_lhs ? {32'b0, mul_lhs} : {{32{mul_lhs[31]}}, mul_lhs};
    mul_b64 = mul_u_rhs ? {32'b0, mul_rhs} : {{32{mul_rhs[31]}}, mul_rhs};
    mul_res = mul_a64 * mul_b64;
  end

  // Attached divider: DIV_LAT register stages, RISC-V corner-case results.
  logic [31:0] dq_new, dr_new;
  logic [31:0] dq_pipe [DIV_LAT];
  logic [31:0] dr_pipe [DIV_LAT];
  always_comb begin
    if (div_rhs == 32'd0) begin
      dq_new = '1;
      dr_new = div_lhs;
    end else if (div_u) begin
      dq_new = div_lhs / div_rhs;
      dr_new = div_lhs % div_rhs;
    end else if (div_lhs == 32'h8000_0000 && div_rhs == 32'hFFFF_FFFF) begin
      dq_new = 32'h8000_0000;
      dr_new = 32'd0;
    end else begin
      dq_new = $signed(div_lhs) / $signed(div_rhs);
      dr_new = $signed(div_lhs) % $signed(div_rhs);
    end
  end
  always_ff @(posedge clk) begin
    dq_pipe[0] <= dq_new;
    dr_pipe[0] <= dr_new;
    for (int i = 1; i < DIV_LAT; i++) begin
      dq_pipe[i] <= dq_pipe[i-1];
      dr_pipe[i] <= dr_pipe[i-1];
    end
  end
  assign div_q = dq_pipe[DIV_LAT-1];
  assign div_r = dr_pipe[DIV_LAT-1];

  // Reference: each accepted op becomes one expected result, visible after edge 'vis'.
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               vis;
    bit               is_div;
  } exp_t;
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } got_t;

  exp_t q[$];
  got_t got[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   edge_no  = 0;
  bit   last_acc = 1'b0;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, update the reference, step past the rising edge.
  task automatic tick();
    bit   mul_req, blocked, exp_ready, exp_valid, acc;
    exp_t e;
    @(negedge clk);
    mul_req = !req_op[2];
    blocked = 1'b0;
    foreach (q[i]) if (q[i].is_div && q[i].vis >= edge_no) blocked = 1'b1;
    exp_ready = !flush && (q.size() < OUT_DEPTH) && !(mul_req && blocked);
    exp_valid = 1'b0;
    if (q.size() > 0) exp_valid = (q[0].vis < edge_no);
    chk_b("req_ready", req_ready, exp_ready);
    chk_b("resp_valid", resp_valid, exp_valid);
    if (exp_valid) begin
      chk("resp_data", resp_data, q[0].data);
      chk("resp_tag", 32'(resp_tag), 32'(q[0].tag));
    end
    chk_b("mul_u_rhs", mul_u_rhs, req_op == 3'd2 || req_op == 3'd3);
    chk_b("div_u", div_u, req_op == 3'd5 || req_op == 3'd7);
    chk("div_rhs", div_rhs, req_rhs);
    if (resp_valid && resp_ready) got.push_back('{resp_data, resp_tag});
    acc = req_valid && exp_ready;
    if (exp_valid && resp_ready) void'(q.pop_front());
    if (flush) begin
      q.delete();
    end else if (acc) begin
      e.data   = ref_result(req_op, req_lhs, req_rhs);
      e.tag    = req_tag;
      e.vis    = mul_req ? edge_no : edge_no + DIV_LAT;
      e.is_div = !mul_req;
      q.push_back(e);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, output int waits);
    req_valid = 1'b1;
    req_op    = op;
    req_lhs   = a;
    req_rhs   = b;
    req_tag   = t;
    waits     = 0;
    last_acc  = 1'b0;
    while (!last_acc && waits < 50) begin
      tick();
      waits++;
    end
    chk_b("issue_accepted", last_acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic take(input string name, input logic [31:0] d, input logic [TAG_W-1:0] t);
    got_t g;
    chk_b({name, "_present"}, got.size() > 0, 1'b1);
    if (got.size() > 0) begin
      g = got.pop_front();
      chk({name, "_data"}, g.data, d);
      chk({name, "_tag"}, 32'(g.tag), 32'(t));
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w;
    int acc_cnt;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_b("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    req_op = 3'd4;
    #1;
    chk_b("rst_ready_div", req_ready, 1'b1);
    req_op = 3'd0;
    #1;
    chk_b("rst_ready_mul", req_ready, 1'b1);
    tick();

    // Multiplies
    resp_ready = 1'b1;
    got.delete();
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, w);
    repeat (2) tick();
    take("mul_7x-3", 32'hFFFF_FFEB, 5'd1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, w);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, w);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, w);
    repeat (3) tick();
    take("mulhsu", 32'hFFFF_FFFF, 5'd2);
    take("mulhu", 32'hFFFF_FFFE, 5'd3);
    take("mulh", 32'h0000_0000, 5'd4);

    // Back-to-back divides including divide-by-zero
    issue(3'd4, 32'd100, 32'd7, 5'd5, w);
    issue(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd6, w);
    issue(3'd5, 32'd5, 32'd0, 5'd7, w);
    repeat (8) tick();
    take("div_100_7", 32'd14, 5'd5);
    take("rem_m100_7", 32'hFFFF_FFFE, 5'd6);
    take("divu_5_0", 32'hFFFF_FFFF, 5'd7);

    // Multiply behind a divide stalls until the tracker drains
    issue(3'd4, 32'd9, 32'd2, 5'd8, w);
    issue(3'd0, 32'd3, 32'd3, 5'd9, w);
    chk("mul_stall_ticks", 32'(w), 32'(DIV_LAT + 1));
    repeat (3) tick();
    take("order_div", 32'd4, 5'd8);
    take("order_mul", 32'd9, 5'd9);

    // Backpressure: credit limits acceptance to OUT_DEPTH
    got.delete();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_op     = 3'd5;
    req_rhs    = 32'd1;
    acc_cnt    = 0;
    for (int k = 0; k < 8; k++) begin
      req_lhs = 32'(100 + acc_cnt);
      req_tag = TAG_W'(10 + acc_cnt);
      tick();
      acc_cnt += int'(last_acc);
    end
    chk("bp_accepted", 32'(acc_cnt), 32'(OUT_DEPTH));
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (6) tick();
    for (int k = 0; k < 4; k++) take("bp_drain", 32'(100 + k), TAG_W'(10 + k));

    // Flush with three divides in flight and one result buffered
    got.delete();
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) issue(3'd4, 32'd50, 32'd5, TAG_W'(20 + k), w);
    tick();
    chk_b("flush_pre_buffered", resp_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_b("flush_post_valid", resp_valid, 1'b0);
    resp_ready = 1'b1;
    issue(3'd0, 32'd6, 32'd7, 5'd24, w);
    chk("flush_mul_wait", 32'(w), 32'd1);
    repeat (7) tick();
    take("flush_mul", 32'd42, 5'd24);
    chk("flush_no_stale", 32'(got.size()), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      req_valid  = ($urandom_range(0, 9) < 6);
      req_op     = 3'($urandom);
      req_lhs    = pick_operand();
      req_rhs    = pick_operand();
      req_tag    = TAG_W'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 49) == 0);
      tick();
    end
    req_valid  = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    repeat (12) tick();
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
